// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: one load/store at a time to a word memory port.
// Raw read word, byte offset and funct3 go to the load-alignment stage.
module lsu_mem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic            mem_we,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic [1:0]      rsp_sft,
  output logic [2:0]      rsp_funct3,
  output logic            rsp_misalign,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:2] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      sft_q, sft_d;
  logic            we_q, we_d;
  logic            mis_q, mis_d;

  logic            accept;
  logic            f3_legal;
  logic            in_mis;
  logic [1:0]      in_sft;
  logic [3:0]      in_strb;
  logic [XLEN-1:0] in_wdata;

  assign accept = req_valid && (state_q == S_IDLE);
  assign in_sft = req_addr[1:0];

  // Decode funct3 legality, alignment, strobes and lane-shifted data
  always_comb begin
    f3_legal = 1'b0;
    in_strb  = 4'b0000;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_we;
      default:                f3_legal = 1'b0;
    endcase
    in_mis = !f3_legal
           || (req_funct3[1:0] == 2'b10 && in_sft != 2'b00)
           || (req_funct3[1:0] == 2'b01 && in_sft == 2'b11);
    unique case (req_funct3[1:0])
      2'b00:   in_strb = 4'b0001 << in_sft;
      2'b01:   in_strb = 4'b0011 << in_sft;
      default: in_strb = 4'b1111;
    endcase
    if (!req_we) in_strb = 4'b0000;
    in_wdata = req_we ? (req_wdata << {in_sft, 3'b000}) : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = in_mis ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_rsp_valid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the request on accept and the read word in WAIT
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    funct3_d = funct3_q;
    sft_d    = sft_q;
    we_d     = we_q;
    mis_d    = mis_q;
    rdata_d  = rdata_q;
    if (accept) begin
      addr_d   = req_addr[XLEN-1:2];
      wdata_d  = in_wdata;
      wstrb_d  = in_strb;
      funct3_d = req_funct3;
      sft_d    = in_sft;
      we_d     = req_we;
      mis_d    = in_mis;
    end
    if (state_q == S_WAIT && mem_rsp_valid) rdata_d = mem_rdata;
  end

  // Datapath registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      sft_q    <= '0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      funct3_q <= funct3_d;
      sft_q    <= sft_d;
      we_q     <= we_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decoded from state and registered fields only
  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = 4'b0000;
    mem_we        = 1'b0;
    rsp_data      = '0;
    rsp_misalign  = 1'b0;
    busy          = (state_q != S_IDLE);
    rsp_sft       = sft_q;
    rsp_funct3    = funct3_q;
    unique case (1'b1)
      (state_q == S_IDLE): req_ready = 1'b1;
      (state_q == S_REQ): begin
        mem_req_valid = 1'b1;
        mem_addr      = {addr_q, 2'b00};
        mem_wdata     = wdata_q;
        mem_wstrb     = wstrb_q;
        mem_we        = we_q;
      end
      (state_q == S_DONE): begin
        rsp_valid    = 1'b1;
        rsp_misalign = mis_q;
        rsp_data     = (mis_q || we_q) ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data and address width; only 32 is supported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 req_valid  input  1  SHALL indicate a load/store request from the execute stage.
REQ-005 req_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-006 req_we  input  1  SHALL be 1 for a store and 0 for a load.
REQ-007 req_addr  input  32  SHALL be the byte address.
REQ-008 req_wdata  input  32  SHALL be the unshifted store data, LSB-justified.
REQ-009 req_funct3  input  3  SHALL be the RISC-V load/store funct3.
REQ-010 mem_req_valid  output  1, mem_req_ready  input  1  SHALL form the memory request handshake.
REQ-011 mem_addr  output  32, mem_wdata  output  32, mem_wstrb  output  4, mem_we  output  1  SHALL be the memory request payload.
REQ-012 mem_rsp_valid  input  1, mem_rdata  input  32  SHALL form the memory response (read data, or store acknowledge).
REQ-013 rsp_valid  output  1, rsp_data  output  32, rsp_sft  output  2, rsp_funct3  output  3  SHALL feed the downstream load-alignment stage: raw word, byte offset, funct3.
REQ-014 rsp_misalign  output  1  SHALL flag a misaligned or illegal access; busy  output  1  SHALL be 1 when not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-016 req_ready SHALL be 1 exactly in IDLE; a request is accepted when req_valid && req_ready && rst_n.
REQ-017 On accept, the block SHALL register addr, we, wdata, funct3, and sft = req_addr[1:0].
REQ-018 Legal funct3: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW; any other value SHALL be treated as misaligned.
REQ-019 Misaligned: word access with sft != 00; halfword access with sft == 11; byte access never.
REQ-020 A misaligned accept SHALL go IDLE->DONE, issue no memory request, and in DONE drive rsp_misalign=1, rsp_data=0.
REQ-021 A legal accept SHALL go IDLE->REQ; in REQ mem_req_valid=1 with mem_addr={addr[31:2],2'b00}, mem_we=we, payload held stable until mem_req_ready.
REQ-022 Store strobes: SB 4'b0001<<sft, SH 4'b0011<<sft, SW 4'b1111; mem_wdata = wdata<<(8*sft), truncated to 32 bits; loads drive mem_wstrb=0, mem_wdata=0.
REQ-023 REQ SHALL move to WAIT on the cycle mem_req_valid && mem_req_ready.
REQ-024 WAIT SHALL capture mem_rdata and move to DONE on mem_rsp_valid; mem_rsp_valid in any other state SHALL be ignored.
REQ-025 DONE SHALL last exactly one cycle with rsp_valid=1 and then return to IDLE; rsp_data = captured word for loads, 0 for stores; rsp_sft, rsp_funct3 = registered values.
REQ-026 Minimum legal latency (zero-wait memory, rsp one cycle after grant) SHALL be 3 cycles from accept to rsp_valid; misaligned latency SHALL be 1 cycle.
REQ-027 A new request SHALL NOT be accepted in DONE; back-to-back throughput is one access per 4 cycles minimum.
REQ-028 All outputs other than req_ready SHALL be registered or decoded from state only (no input-to-output combinational path).

Reset
REQ-029 While rst_n=0 at a clock edge: state->IDLE; rsp_valid, rsp_misalign, mem_req_valid, busy SHALL be 0; rsp_data, rsp_sft, rsp_funct3, mem_addr, mem_wdata, mem_wstrb, mem_we SHALL be 0.
REQ-030 Reset in REQ or WAIT SHALL abandon the access; mem_req_valid SHALL be 0 from the following cycle and no rsp_valid SHALL be produced for it.

Verification
REQ-031 LW addr 0x100, mem_rdata 0xDEADBEEF, zero-wait -> rsp_valid 3 cycles after accept, rsp_data 0xDEADBEEF, rsp_sft 00, mem_addr 0x100.
REQ-032 SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, mem_wstrb 4'b1000, mem_wdata 0xA5000000, rsp_data 0 after ack.
REQ-033 SH addr 0x301 wdata 0x1234 -> mem_wstrb 4'b0110, mem_wdata 0x00123400; LH addr 0x303 -> rsp_misalign=1 one cycle after accept, mem_req_valid never asserted.
REQ-034 LBU addr 0x402 with mem_req_ready low 5 cycles and response 3 cycles later -> payload stable throughout REQ, rsp_valid once, rsp_sft 10.
REQ-035 rst_n low during WAIT, then stray mem_rsp_valid after reset -> no rsp_valid, state IDLE, req_ready 1.
REQ-036 funct3 3'b011 load -> rsp_misalign=1, rsp_data 0, no memory request.
